game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 15, score that ends the match (1..15).
REQ-002 Parameter PAUSE_FRAMES, default 60, frames frozen after a point (1..255).
REQ-003 Parameter SERVE_FRAMES, default 30, frames the ball is held at the serve position (1..255).
REQ-004 clk  in  1  65 MHz pixel clock; the only clock.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse per frame (vsync start).
REQ-007 start_click  in  1  level, mouse left button, already synchronised to clk.
REQ-008 gnd_col  in  1  level, ball touches ground.
REQ-009 ball_side  in  1  ball half: 0 = player-1 half, 1 = player-2 half.
REQ-010 ovr_touch  in  1  level, the current side has exceeded three touches.
REQ-011 last_touch  in  1  last player to touch the ball: 0 = player 1, 1 = player 2.
REQ-012 ball_rst  out  1  holds the ball controller at the serve position.
REQ-013 serve_side  out  1  serving player: 0 = player 1, 1 = player 2.
REQ-014 freeze  out  1  stops ball physics.
REQ-015 score_pl1, score_pl2  out  4 each  scores.
REQ-016 flag_point  out  1  one-cycle pulse when a point is awarded.
REQ-017 point_winner  out  1  winner of the most recent point.
REQ-018 endgame  out  1  high while in state OVER.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, SERVE, RALLY, PAUSE, OVER.
REQ-020 IDLE: ball_rst=1 and freeze=1; a start_click rising edge (0->1 between consecutive cycles) SHALL move to SERVE on the next cycle.
REQ-021 SERVE: ball_rst=1 and freeze=0; the state SHALL move to RALLY after SERVE_FRAMES frame_tick pulses.
REQ-022 RALLY: ball_rst=0 and freeze=0; gnd_col=1 SHALL award the point to player (~ball_side).
REQ-023 RALLY: ovr_touch=1 with gnd_col=0 SHALL award the point to player (~last_touch).
REQ-024 If gnd_col and ovr_touch are high in the same cycle, gnd_col SHALL take priority.
REQ-025 Point award, single cycle: increment the winner's score (saturate at 15), set point_winner, pulse flag_point, set serve_side to the winner, and enter PAUSE (or OVER if the winner's new score equals WIN_SCORE).
REQ-026 Latency: flag_point and the updated score SHALL be visible one cycle after the qualifying input sample.
REQ-027 The block SHALL award at most one point per RALLY entry; inputs outside RALLY SHALL be ignored.
REQ-028 PAUSE: freeze=1 and ball_rst=0; the state SHALL move to SERVE after PAUSE_FRAMES frame_tick pulses.
REQ-029 OVER: freeze=1, ball_rst=1, endgame=1; a start_click rising edge SHALL clear both scores, set serve_side=0, and go to SERVE.
REQ-030 A click held across a state change SHALL NOT act as a new edge.
REQ-031 The frame counter SHALL clear on every state entry and count only on frame_tick.
REQ-032 A frame_tick coinciding with a state entry SHALL NOT be counted.
REQ-033 The frame counter SHALL be 8 bits wide; it SHALL NOT wrap before reaching its terminal count.
REQ-034 The first match serve SHALL go to player 1 (serve_side=0).

Reset
REQ-035 rst SHALL asynchronously force: state=IDLE, scores=0, serve_side=0, point_winner=0, flag_point=0, endgame=0, ball_rst=1, freeze=1, frame counter=0, click-edge register=0.
REQ-036 Reset asserted mid-RALLY or mid-PAUSE SHALL abort the point with no flag_point pulse.
REQ-037 Operation SHALL resume only from IDLE after rst deasserts.

Structure
REQ-038 State encodings, WIN_SCORE/PAUSE_FRAMES/SERVE_FRAMES defaults, and the player index constants (PL1=0, PL2=1) SHALL live in the shared game macros header.
REQ-039 One sub-module, frame_timer, SHALL hold the 8-bit counter: clear input, tick input, terminal-count input, and a done output.
REQ-040 All outputs SHALL be registered.

Verification
REQ-041 Reset, then start_click 0->1 -> SERVE next cycle; after 30 frame_ticks -> RALLY, with ball_rst falling.
REQ-042 RALLY with gnd_col=1, ball_side=0 -> one cycle later score_pl2=1, flag_point pulses once, serve_side=1, state=PAUSE; after 60 ticks -> SERVE.
REQ-043 RALLY with gnd_col=1, ovr_touch=1, ball_side=1, last_touch=1 -> player 1 scores (gnd_col priority).
REQ-044 score_pl1=14 with WIN_SCORE=15, then a player-1 point -> score_pl1=15, endgame=1; click held across the transition -> stays OVER; release then click -> scores 0, SERVE.
REQ-045 rst pulsed for 3 cycles mid-PAUSE -> all outputs at reset values asynchronously; no flag_point; scores 0.
REQ-046 gnd_col held high for 100 cycles in RALLY -> exactly one point awarded.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the match controller.
package game_ctrl_pkg;

  localparam int unsigned SCORE_W          = 4;
  localparam int unsigned FRAME_W          = 8;
  localparam int unsigned WIN_SCORE_DEF    = 15;
  localparam int unsigned PAUSE_FRAMES_DEF = 60;
  localparam int unsigned SERVE_FRAMES_DEF = 30;

  localparam logic PL1 = 1'b0;
  localparam logic PL2 = 1'b1;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Per-state control outputs, registered together with the state.
  typedef struct packed {
    logic ball_rst;
    logic freeze;
    logic endgame;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '{ball_rst: 1'b1, freeze: 1'b1, endgame: 1'b0};
    case (s)
      SERVE: c.freeze = 1'b0;
      RALLY: begin
        c.ball_rst = 1'b0;
        c.freeze   = 1'b0;
      end
      PAUSE: c.ball_rst = 1'b0;
      OVER:  c.endgame  = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter: clears on state entry, counts frame ticks, pulses done on
// the tick that reaches the terminal count and then holds without wrapping.
module frame_timer
  import game_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  input  logic [FRAME_W-1:0] tc,
  output logic               done
);

  logic [FRAME_W-1:0] count;

  // A tick arriving together with clear is dropped, not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick && (count != tc)) begin
        count <= count + FRAME_W'(1);
        done  <= (count == tc - FRAME_W'(1));
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Match controller: serve/rally/pause sequencing, point awarding and scoring.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned PAUSE_FRAMES = PAUSE_FRAMES_DEF,
  parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_click,
  input  logic               gnd_col,
  input  logic               ball_side,
  input  logic               ovr_touch,
  input  logic               last_touch,
  output logic               ball_rst,
  output logic               serve_side,
  output logic               freeze,
  output logic [SCORE_W-1:0] score_pl1,
  output logic [SCORE_W-1:0] score_pl2,
  output logic               flag_point,
  output logic               point_winner,
  output logic               endgame
);

  localparam logic [FRAME_W-1:0] SERVE_TC = FRAME_W'(SERVE_FRAMES);
  localparam logic [FRAME_W-1:0] PAUSE_TC = FRAME_W'(PAUSE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  state_t             state;
  ctrl_t              ctrl;
  logic               entry;
  logic               click_q;
  logic               timer_done;
  logic               click_rise_c;
  logic               win_c;
  logic [SCORE_W-1:0] win_score_c;
  logic [FRAME_W-1:0] tc_c;

  // Ground contact decides by ball half; otherwise the over-touch goes
  // against the last toucher.
  assign click_rise_c = start_click & ~click_q;
  assign win_c        = gnd_col ? ~ball_side : ~last_touch;
  assign win_score_c  = sat_inc((win_c == PL2) ? score_pl2 : score_pl1);
  assign tc_c         = (state == PAUSE) ? PAUSE_TC : SERVE_TC;

  assign ball_rst = ctrl.ball_rst;
  assign freeze   = ctrl.freeze;
  assign endgame  = ctrl.endgame;

  frame_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (entry),
    .tick  (frame_tick),
    .tc    (tc_c),
    .done  (timer_done)
  );

  // State, control outputs and scores advance together; entry flags the
  // first cycle of every new state so the frame timer restarts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ctrl         <= state_ctrl(IDLE);
      entry        <= 1'b0;
      click_q      <= 1'b0;
      score_pl1    <= '0;
      score_pl2    <= '0;
      serve_side   <= PL1;
      point_winner <= PL1;
      flag_point   <= 1'b0;
    end else begin
      click_q    <= start_click;
      entry      <= 1'b0;
      flag_point <= 1'b0;
      case (state)
        IDLE: begin
          if (click_rise_c) begin
            state <= SERVE;
            ctrl  <= state_ctrl(SERVE);
            entry <= 1'b1;
          end
        end
        SERVE: begin
          if (timer_done) begin
            state <= RALLY;
            ctrl  <= state_ctrl(RALLY);
            entry <= 1'b1;
          end
        end
        RALLY: begin
          if (gnd_col || ovr_touch) begin
            point_winner <= win_c;
            serve_side   <= win_c;
            flag_point   <= 1'b1;
            if (win_c == PL2) score_pl2 <= win_score_c;
            else              score_pl1 <= win_score_c;
            entry <= 1'b1;
            if (win_score_c == WIN_VAL) begin
              state <= OVER;
              ctrl  <= state_ctrl(OVER);
            end else begin
              state <= PAUSE;
              ctrl  <= state_ctrl(PAUSE);
            end
          end
        end
        PAUSE: begin
          if (timer_done) begin
            state <= SERVE;
            ctrl  <= state_ctrl(SERVE);
            entry <= 1'b1;
          end
        end
        OVER: begin
          if (click_rise_c) begin
            score_pl1  <= '0;
            score_pl2  <= '0;
            serve_side <= PL1;
            state      <= SERVE;
            ctrl       <= state_ctrl(SERVE);
            entry      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ctrl  <= state_ctrl(IDLE);
          entry <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl; point awards are checked by a flag_point monitor.
module tb_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'b110;  // {ball_rst, freeze, endgame}
  localparam logic [2:0] S_SERVE = 3'b100;
  localparam logic [2:0] S_RALLY = 3'b000;
  localparam logic [2:0] S_PAUSE = 3'b010;
  localparam logic [2:0] S_OVER  = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_click = 1'b0;
  logic       gnd_col = 1'b0;
  logic       ball_side = 1'b0;
  logic       ovr_touch = 1'b0;
  logic       last_touch = 1'b0;
  logic       ball_rst, serve_side, freeze, flag_point, point_winner, endgame;
  logic [3:0] score_pl1, score_pl2;

  typedef struct packed {
    logic       winner;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       serve;
    logic       over;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_exp, mon_act;
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] m_s1 = 4'd0;
  logic [3:0] m_s2 = 4'd0;

  game_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start_click  (start_click),
    .gnd_col      (gnd_col),
    .ball_side    (ball_side),
    .ovr_touch    (ovr_touch),
    .last_touch   (last_touch),
    .ball_rst     (ball_rst),
    .serve_side   (serve_side),
    .freeze       (freeze),
    .score_pl1    (score_pl1),
    .score_pl2    (score_pl2),
    .flag_point   (flag_point),
    .point_winner (point_winner),
    .endgame      (endgame)
  );

  always #5 clk = ~clk;

  // Monitor: every flag_point pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && flag_point) begin
      n_vec++;
      mon_act = '{winner: point_winner, s1: score_pl1, s2: score_pl2,
                  serve: serve_side, over: endgame};
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_point: got flag_point=1 %h expected no point at %0t", mon_act, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL point_award: got {w,s1,s2,serve,over}=%h expected %h at %0t",
                   mon_act, mon_exp, $time);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step(2);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    check(name, 32'({ball_rst, freeze, endgame}), 32'(exp));
  endtask

  task automatic check_scores(input string name);
    check(name, 32'({score_pl1, score_pl2}), 32'({m_s1, m_s2}));
  endtask

  task automatic expect_point(input logic w);
    exp_t e;
    if (w) m_s2 = (m_s2 == 4'd15) ? m_s2 : 4'(m_s2 + 4'd1);
    else   m_s1 = (m_s1 == 4'd15) ? m_s1 : 4'(m_s1 + 4'd1);
    e.winner = w;
    e.s1     = m_s1;
    e.s2     = m_s2;
    e.serve  = w;
    e.over   = ((w ? m_s2 : m_s1) == 4'd15);
    sb_q.push_back(e);
  endtask

  task automatic point(input logic g, input logic o, input logic side, input logic last,
                       input logic click = 1'b0);
    logic w;
    w = g ? ~side : ~last;
    expect_point(w);
    gnd_col     = g;
    ovr_touch   = o;
    ball_side   = side;
    last_touch  = last;
    start_click = click;
    step();
    gnd_col   = 1'b0;
    ovr_touch = 1'b0;
    check_state("point_next_state", (((w ? m_s2 : m_s1) == 4'd15) ? S_OVER : S_PAUSE));
  endtask

  task automatic serve_to_rally();
    step(2);
    tick_frames(29);
    check_state("serve_hold", S_SERVE);
    tick_frames(1);
    check_state("serve_done", S_RALLY);
  endtask

  task automatic pause_to_serve();
    step(2);
    tick_frames(59);
    check_state("pause_hold", S_PAUSE);
    tick_frames(1);
    check_state("pause_done", S_SERVE);
  endtask

  initial begin
    step(3);
    check_state("reset_state", S_IDLE);
    check_scores("reset_scores");
    check("reset_flags", 32'({flag_point, point_winner, serve_side}), 32'(3'b000));
    rst = 1'b0;
    step(2);
    check_state("idle_after_reset", S_IDLE);

    // Click into SERVE; the first tick lands on the entry cycle and is dropped.
    start_click = 1'b1;
    step();
    start_click = 1'b0;
    check_state("click_to_serve", S_SERVE);
    check("first_serve_side", 32'(serve_side), 32'(1'b0));
    tick_frames(30);
    check_state("entry_tick_dropped", S_SERVE);
    tick_frames(1);
    check_state("serve_to_rally", S_RALLY);

    point(1'b1, 1'b0, 1'b0, 1'b0);          // ground on P1 half: P2 scores
    check("serve_side_p2", 32'(serve_side), 32'(1'b1));
    pause_to_serve();
    serve_to_rally();

    point(1'b1, 1'b1, 1'b1, 1'b1);          // ground beats over-touch: P1 scores
    pause_to_serve();
    serve_to_rally();

    point(1'b0, 1'b1, 1'b0, 1'b0);          // P1 over-touched: P2 scores
    gnd_col   = 1'b1;
    ovr_touch = 1'b1;
    step(10);
    gnd_col   = 1'b0;
    ovr_touch = 1'b0;
    check_state("pause_ignores_inputs", S_PAUSE);
    check_scores("pause_scores_stable");
    pause_to_serve();
    serve_to_rally();

    // Ground held for 100 cycles: a single award.
    expect_point(1'b0);
    gnd_col   = 1'b1;
    ball_side = 1'b1;
    step(100);
    gnd_col = 1'b0;
    check_state("held_gnd_one_point", S_PAUSE);
    check_scores("held_gnd_scores");

    while (m_s1 < 4'd14) begin
      pause_to_serve();
      serve_to_rally();
      point(1'b1, 1'b0, 1'b1, 1'b0);
    end
    check("p1_at_14", 32'(score_pl1), 32'(4'd14));

    // Winning point with the click already pressed; it must not restart.
    pause_to_serve();
    serve_to_rally();
    point(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(5);
    check_state("held_click_stays_over", S_OVER);
    check("win_score", 32'(score_pl1), 32'(4'd15));
    start_click = 1'b0;
    step();
    start_click = 1'b1;
    step();
    start_click = 1'b0;
    m_s1 = 4'd0;
    m_s2 = 4'd0;
    check_state("over_click_to_serve", S_SERVE);
    check_scores("over_scores_cleared");
    check("over_serve_side", 32'(serve_side), 32'(1'b0));

    // Reset mid-PAUSE, applied between clock edges.
    serve_to_rally();
    point(1'b1, 1'b0, 1'b0, 1'b0);
    tick_frames(10);
    #2;
    rst = 1'b1;
    #1;
    m_s1 = 4'd0;
    m_s2 = 4'd0;
    check_state("async_reset_state", S_IDLE);
    check_scores("async_reset_scores");
    check("async_reset_flags", 32'({flag_point, point_winner, serve_side}), 32'(3'b000));
    step(3);
    rst = 1'b0;
    step(2);
    check_state("idle_after_pause_reset", S_IDLE);

    // Reset together with a ground contact in RALLY: no award.
    start_click = 1'b1;
    step();
    start_click = 1'b0;
    check_state("restart_serve", S_SERVE);
    serve_to_rally();
    gnd_col = 1'b1;
    rst     = 1'b1;
    step(3);
    check("rally_reset_no_flag", 32'(flag_point), 32'(1'b0));
    rst = 1'b0;
    step(2);
    gnd_col = 1'b0;
    check_state("idle_after_rally_reset", S_IDLE);
    check_scores("rally_reset_scores");
    start_click = 1'b1;
    step();
    start_click = 1'b0;
    check_state("resume_from_idle", S_SERVE);

    step(5);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
